// File: rtl/sys_rst_seq_pkg.sv
// sys_rst_seq_pkg: FSM state and reset-cause encodings shared by the reset sequencer,
// plus a helper that sizes counters.
package sys_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_BTN       = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam int CAUSE_W = 2;

  localparam logic [CAUSE_W-1:0] CAUSE_POR  = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_BTN  = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_LOCK = 2'd2;

  // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_rst_seq_btn_debounce.sv
// btn_debounce: synchronises the raw push-button and accepts a level change only after
// DEBOUNCE_CYCLES consecutive stable cycles. o_pressed is active-high for either board polarity.
module btn_debounce
  import sys_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pressed
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   w_btn_pressed_raw;
  logic                   w_btn_s;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_deb;

  // Normalise polarity before the synchroniser so a cleared chain means "not pressed".
  assign w_btn_pressed_raw = (BTN_ACTIVE_LOW != 0) ? ~i_btn : i_btn;
  assign w_btn_s           = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn_pressed_raw};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (w_btn_s == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_deb <= ~r_deb;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_pressed = r_deb;

endmodule

// File: rtl/sys_rst_seq.sv
// sys_rst_seq: merges power-on reset, debounced push-button and (with SYS_RST_SEQ_LOCK_EN)
// PLL lock into one system reset: async assert, sync deassert after a hold, last cause kept.
module sys_rst_seq
  import sys_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic               clki,
  input  logic               rst,
  input  logic               btn,
`ifdef SYS_RST_SEQ_LOCK_EN
  input  logic               locked,
`endif
  output logic               sys_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic [CAUSE_W-1:0] cause
);

  localparam int                HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("sys_rst_seq: SYNC_STAGES must be in 2..4");
    end
    if (HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_count
      $error("sys_rst_seq: HOLD_CYCLES and DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  state_t               r_state;
  state_t               w_state_next;
  logic [HOLD_W-1:0]    r_hold;
  logic [HOLD_W-1:0]    w_hold_next;
  logic [CAUSE_W-1:0]   r_cause;
  logic [CAUSE_W-1:0]   w_cause_next;
  logic                 r_sys_rst;
  logic                 r_ready;
  logic                 w_pressed;
  logic                 w_locked_s;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_btn_debounce (
    .i_clk    (clki),
    .i_rst    (rst),
    .i_btn    (btn),
    .o_pressed(w_pressed)
  );

`ifdef SYS_RST_SEQ_LOCK_EN
  logic [SYNC_STAGES-1:0] r_lock_sync;

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
`else
  assign w_locked_s = 1'b1;
`endif

  // Lock loss outranks a button press in every state where it causes a transition.
  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_hold_next  = '0;
    unique case (r_state)
      ST_RESET: begin
        w_state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_pressed) begin
          w_state_next = ST_BTN;
          w_cause_next = CAUSE_BTN;
        end else if (w_locked_s) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_locked_s) begin
          w_state_next = ST_WAIT_LOCK;
          w_cause_next = CAUSE_LOCK;
        end else if (w_pressed) begin
          w_state_next = ST_BTN;
          w_cause_next = CAUSE_BTN;
        end else if (r_hold == HOLD_LAST) begin
          w_state_next = ST_RUN;
        end else begin
          w_hold_next = r_hold + HOLD_W'(1);
        end
      end
      ST_BTN: begin
        if (!w_locked_s) begin
          w_state_next = ST_WAIT_LOCK;
          w_cause_next = CAUSE_LOCK;
        end else if (!w_pressed) begin
          w_state_next = ST_WAIT_LOCK;
        end
      end
      ST_RUN: begin
        if (!w_locked_s) begin
          w_state_next = ST_WAIT_LOCK;
          w_cause_next = CAUSE_LOCK;
        end else if (w_pressed) begin
          w_state_next = ST_BTN;
          w_cause_next = CAUSE_BTN;
        end
      end
      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as r_state.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_hold    <= '0;
      r_cause   <= CAUSE_POR;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      r_cause   <= w_cause_next;
      r_sys_rst <= (w_state_next != ST_RUN);
      r_ready   <= (w_state_next == ST_RUN);
    end
  end

  assign sys_rst   = r_sys_rst;
  assign sys_rst_n = ~r_sys_rst;
  assign ready     = r_ready;
  assign cause     = r_cause;

endmodule

// File: doc/sys_rst_seq.md
Name: sys_rst_seq

Overview:
- Reset sequencer directly downstream of the 12→50 MHz PLL.
- Clocked by the PLL output clock. Combines power-on reset, the board push-button and (optionally) PLL lock into one clean system reset for the SoC fabric.
- Reset assertion is asynchronous; deassertion is synchronous to clki, after a fixed hold time. Reports the cause of the last reset.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for btn and locked; legal range 2..4.
- HOLD_CYCLES, 1024: clki cycles sys_rst is held after all reset sources clear; minimum 1.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a button level change (1 ms at 50 MHz); minimum 1.
- BTN_ACTIVE_LOW, 1: 1 means btn=0 is "pressed".

Ports:
- clki  in  1  PLL output clock (50 MHz).
- rst  in  1  asynchronous, active-high power-on/board reset.
- btn  in  1  raw asynchronous push-button.
- locked  in  1  PLL lock, asynchronous. Present only with SYS_RST_SEQ_LOCK_EN.
- sys_rst  out  1  active-high system reset; async assert, sync deassert.
- sys_rst_n  out  1  always the inverse of sys_rst.
- ready  out  1  high only in RUN.
- cause  out  2  cause of last reset: 0 power-on, 1 button, 2 lock loss; 3 unused.

Behaviour:
- One clock, clki. rst is asynchronous, active-high.
- While rst=1:
  - state=RESET, sys_rst=1, sys_rst_n=0, ready=0, cause=0.
  - Hold and debounce counters are 0.
  - Synchroniser flops are cleared to "not locked" / "not pressed".
  - Debounced button state is "released".
- btn is synchronised through SYNC_STAGES flops, then debounced:
  - A counter increments every cycle the synchronised level differs from the debounced level and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level toggles on the next edge and the counter clears.
- locked is synchronised through SYNC_STAGES flops to give locked_s.
- FSM states: RESET, WAIT_LOCK, HOLD, BTN, RUN.
  - RESET → WAIT_LOCK on the first clki edge after rst falls.
  - WAIT_LOCK: on locked_s=1 → HOLD, hold counter = 0.
  - HOLD: counter increments each cycle. At HOLD_CYCLES-1 → RUN.
  - RUN: sys_rst=0, sys_rst_n=1, ready=1.
  - Debounced press in WAIT_LOCK, HOLD or RUN → BTN, cause=1.
  - BTN: waits for debounced release → WAIT_LOCK.
  - locked_s=0 in HOLD, BTN or RUN → WAIT_LOCK, cause=2, hold counter cleared.
- Priority: rst > lock loss > button. If lock loss and a debounced press arrive in the same cycle, the next state is WAIT_LOCK and cause=2.
- sys_rst and ready are registered, decoded from the next state, so they change on the same edge as the state register. sys_rst=1 in every state except RUN.
- Latency: with locked high and steady, sys_rst falls on rising edge SYNC_STAGES+1+HOLD_CYCLES after rst falls.
- cause updates only on entry to BTN or on a lock-loss transition. It holds its value through RUN.
- rst asserted mid-operation: outputs go to their reset values immediately (asynchronously) and the sequence restarts from RESET.

Optional Feature:
- Macro: SYS_RST_SEQ_LOCK_EN.
- Defined: the locked port exists and is synchronised; lock-loss transitions and cause=2 are active.
- Undefined: no locked port. locked_s is constant 1, so WAIT_LOCK always exits on the next edge and cause never equals 2. Release latency becomes 2+HOLD_CYCLES edges.

Decomposition:
- Package sys_rst_seq_pkg holds:
  - state enum (RESET, WAIT_LOCK, HOLD, BTN, RUN);
  - cause constants CAUSE_POR=0, CAUSE_BTN=1, CAUSE_LOCK=2;
  - cause width constant of 2.
- One sub-module, btn_debounce: synchroniser plus debounce counter, parameterised by SYNC_STAGES, DEBOUNCE_CYCLES and BTN_ACTIVE_LOW. Output: active-high debounced "pressed".
- FSM and hold counter live in the top module.

Test Plan (SYNC_STAGES=2, HOLD_CYCLES=16, DEBOUNCE_CYCLES=8, macro defined unless noted):
1. rst high 5 cycles, locked=1, btn released → sys_rst falls and ready rises on edge 19 after rst falls; cause=0; sys_rst_n always equals ~sys_rst.
2. In RUN, btn pulses pressed for 3, 5 and 7 cycles with gaps of 4 → no sys_rst assertion, ready stays 1.
3. In RUN, btn pressed and held 20 cycles → sys_rst rises 11 edges after the press begins; cause=1. After release, sys_rst falls 11+1+16 edges after release.
4. In RUN, locked low for 1 cycle → sys_rst rises on edge 3 after locked falls; cause=2. Relock → sys_rst falls 3+16 edges after locked rises.
5. rst asserted at HOLD count 10 → sys_rst stays 1, ready=0, cause=0. Release → full 19-edge sequence repeats, with no early exit from a stale counter.
6. Lock loss and debounced press in the same cycle → next state WAIT_LOCK, cause=2. With macro undefined, sys_rst falls on edge 18 after rst release.
